// File: rtl/poolb2_cu_pkg.sv
// Shared constants and FSM encoding for the LeNet5 unit-2 second max-pool stage.
// Imported by the interface, the delay line and the control unit.
package poolb2_cu_pkg;

   localparam int IFM_SIZE_C      = 10;
   localparam int IFM_DEPTH_C     = 8;
   localparam int POOL_SIZE_C     = 2;
   localparam int STRIDE_C        = 2;
   localparam int IFM_SIZE_NEXT_C = (IFM_SIZE_C - POOL_SIZE_C) / STRIDE_C + 1;

   localparam int ADDR_W_IFM_C  = $clog2(IFM_SIZE_C * IFM_SIZE_C);
   localparam int ADDR_W_NEXT_C = $clog2(IFM_SIZE_NEXT_C * IFM_SIZE_NEXT_C);
   localparam int SEL_W_C       = $clog2(IFM_DEPTH_C);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_READ      = 2'd1,
      ST_DRAIN     = 2'd2,
      ST_WAIT_NEXT = 2'd3
   } state_t;

endpackage

// File: rtl/poolb2_cu_if.sv
// Handshake and memory-side signals of the pool-2 control unit.
// master = control unit side, slave = surrounding memories / neighbour stages.
interface poolb2_cu_if
   import poolb2_cu_pkg::*;
#(
   parameter int AW_IFM  = ADDR_W_IFM_C,
   parameter int AW_NEXT = ADDR_W_NEXT_C,
   parameter int SEL_W   = SEL_W_C
);
   logic               start_from_previous;
   logic               end_from_next;
   logic               end_to_previous;
   logic               start_to_next;
   logic               ifm_enable_read;
   logic [AW_IFM-1:0]  ifm_address_read;
   logic [SEL_W-1:0]   ifm_sel;
   logic               pool_load;
   logic               pool_enable;
   logic               ofm_enable_write;
   logic [AW_NEXT-1:0] ofm_address_write;
   logic [SEL_W-1:0]   ofm_sel;

   modport master (
      input  start_from_previous, end_from_next,
      output end_to_previous, start_to_next, ifm_enable_read, ifm_address_read,
             ifm_sel, pool_load, pool_enable, ofm_enable_write,
             ofm_address_write, ofm_sel
   );

   modport slave (
      output start_from_previous, end_from_next,
      input  end_to_previous, start_to_next, ifm_enable_read, ifm_address_read,
             ifm_sel, pool_load, pool_enable, ofm_enable_write,
             ofm_address_write, ofm_sel
   );
endinterface

// File: rtl/poolb2_cu_pool_delay_line.sv
// Fixed-length register pipeline aligning control strobes with memory data.
// Latency DELAY cycles (DELAY >= 1); no backpressure, shifts every cycle.
module pool_delay_line #(
   parameter int WIDTH = 1,
   parameter int DELAY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [WIDTH-1:0] pipe [DELAY];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[DELAY-1];
endmodule

// File: rtl/poolb2_cu.sv
// Pool-2 control unit: walks 2x2/stride-2 windows over 8 maps, one read per cycle,
// and emits comparator and write strobes aligned to the 1-cycle memory latency.
module poolb2_cu
   import poolb2_cu_pkg::*;
#(
   parameter int IFM_SIZE              = IFM_SIZE_C,
   parameter int IFM_DEPTH             = IFM_DEPTH_C,
   parameter int POOL_SIZE             = POOL_SIZE_C,
   parameter int STRIDE                = STRIDE_C,
   parameter int IFM_SIZE_NEXT         = (IFM_SIZE - POOL_SIZE) / STRIDE + 1,
   parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
   parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
   input  logic        clk,
   input  logic        reset,
   poolb2_cu_if.master bus
);
   localparam int SEL_W    = $clog2(IFM_DEPTH);
   localparam int CW       = $clog2(IFM_SIZE_NEXT);
   localparam int NPIX     = IFM_SIZE_NEXT * IFM_SIZE_NEXT;
   localparam int WIN_LAST = POOL_SIZE * POOL_SIZE - 1;
   localparam int WR_W     = 1 + ADDRESS_SIZE_NEXT_IFM + SEL_W;

   state_t                           state, state_nxt;
   logic [1:0]                       k;
   logic [CW-1:0]                    col, row;
   logic [SEL_W-1:0]                 map;
   logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr;
   logic [SEL_W-1:0]                 wr_sel;
   logic                             drain_cnt;
   logic                             rd, win_done, last_read;
   logic [1:0]                       pool_d;
   logic [WR_W-1:0]                  wr_d;

   assign rd        = (state == ST_READ);
   assign win_done  = (k == 2'(WIN_LAST));
   assign last_read = rd && win_done && (col == CW'(IFM_SIZE_NEXT - 1))
                      && (row == CW'(IFM_SIZE_NEXT - 1)) && (map == SEL_W'(IFM_DEPTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt           = state;
      bus.end_to_previous = 1'b0;
      bus.start_to_next   = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.end_to_previous = 1'b1;
            if (bus.start_from_previous) state_nxt = ST_READ;
         end
         ST_READ:  if (last_read) state_nxt = ST_DRAIN;
         ST_DRAIN: if (drain_cnt) state_nxt = ST_WAIT_NEXT;
         ST_WAIT_NEXT: begin
            if (bus.end_from_next) begin
               bus.start_to_next = 1'b1;
               state_nxt         = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // All counters wrap back to zero on the final read, so a bank always restarts at window 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k         <= '0;
         col       <= '0;
         row       <= '0;
         map       <= '0;
         wr_addr   <= '0;
         wr_sel    <= '0;
         drain_cnt <= 1'b0;
      end else begin
         drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
         if (rd) begin
            k <= k + 2'd1;
            if (win_done) begin
               if (col == CW'(IFM_SIZE_NEXT - 1)) begin
                  col <= '0;
                  if (row == CW'(IFM_SIZE_NEXT - 1)) begin
                     row <= '0;
                     map <= (map == SEL_W'(IFM_DEPTH - 1)) ? '0 : map + SEL_W'(1);
                  end else begin
                     row <= row + CW'(1);
                  end
               end else begin
                  col <= col + CW'(1);
               end
               if (wr_addr == ADDRESS_SIZE_NEXT_IFM'(NPIX - 1)) begin
                  wr_addr <= '0;
                  wr_sel  <= (wr_sel == SEL_W'(IFM_DEPTH - 1)) ? '0 : wr_sel + SEL_W'(1);
               end else begin
                  wr_addr <= wr_addr + ADDRESS_SIZE_NEXT_IFM'(1);
               end
            end
         end
      end
   end

   assign bus.ifm_enable_read  = rd;
   assign bus.ifm_sel          = map;
   assign bus.ifm_address_read = ADDRESS_SIZE_IFM'(STRIDE * IFM_SIZE * int'(row) + STRIDE * int'(col)
                                                   + IFM_SIZE * int'(k[1]) + int'(k[0]));

   // Comparator strobes follow the data by one cycle; the write waits one more for the final max.
   pool_delay_line #(.WIDTH(2), .DELAY(1)) u_pool_dl (
      .clk   (clk),
      .reset (reset),
      .din   ({rd, rd && (k == 2'd0)}),
      .dout  (pool_d)
   );

   pool_delay_line #(.WIDTH(WR_W), .DELAY(2)) u_wr_dl (
      .clk   (clk),
      .reset (reset),
      .din   ({rd && win_done, wr_addr, wr_sel}),
      .dout  (wr_d)
   );

   assign bus.pool_enable = pool_d[1];
   assign bus.pool_load   = pool_d[0];
   assign {bus.ofm_enable_write, bus.ofm_address_write, bus.ofm_sel} = wr_d;
endmodule

// File: tb/tb_poolb2_cu.sv
// Randomized scoreboard bench for poolb2_cu: a window-walk model queues expected
// reads/strobes/writes per bank, a negedge monitor pops and compares them.
module tb_poolb2_cu;
   import poolb2_cu_pkg::*;

   typedef struct {
      int addr;
      int sel;
      int cyc;
   } acc_t;

   typedef struct {
      int ld;
      int cyc;
   } pl_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   poolb2_cu_if bus ();

   poolb2_cu dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   acc_t rq[$];
   acc_t wq[$];
   pl_t  pq[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   run_active = 1'b0;
   int   pulse_cyc = 0;
   int   pulses_seen = 0;

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Expected bank schedule from the window-walk rule; cycle 1 is the first read.
   task automatic build_model();
      int i = 0;
      for (int m = 0; m < 8; m++)
         for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
               for (int k = 0; k < 4; k++) begin
                  rq.push_back('{2 * r * 10 + 2 * c + (k % 2) + (k / 2) * 10, m, i + 1});
                  pq.push_back('{int'(k == 0), i + 2});
                  if (k == 3) wq.push_back('{r * 5 + c, m, i + 3});
                  i++;
               end
   endtask

   always @(negedge clk) begin
      acc_t e;
      pl_t  p;
      if (!reset) begin
         if (run_active) cyc++;
         else begin
            cyc = 0;
            pulses_seen = 0;
         end
         chk("end_to_previous", int'(bus.end_to_previous),
             run_active ? int'(cyc > pulse_cyc) : 1);
         if (!run_active)
            chk("idle_strobes", int'({bus.ifm_enable_read, bus.pool_enable, bus.pool_load,
                                      bus.ofm_enable_write, bus.start_to_next}), 0);
         if (bus.ifm_enable_read) begin
            if (rq.size() == 0) chk("unexpected_read", 1, 0);
            else begin
               e = rq.pop_front();
               chk("rd_addr", int'(bus.ifm_address_read), e.addr);
               chk("rd_sel", int'(bus.ifm_sel), e.sel);
               chk("rd_cycle", cyc, e.cyc);
            end
         end
         if (bus.pool_enable) begin
            if (pq.size() == 0) chk("unexpected_pool_enable", 1, 0);
            else begin
               p = pq.pop_front();
               chk("pool_load", int'(bus.pool_load), p.ld);
               chk("pool_cycle", cyc, p.cyc);
            end
         end else if (bus.pool_load) chk("stray_pool_load", 1, 0);
         if (bus.ofm_enable_write) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               e = wq.pop_front();
               chk("wr_addr", int'(bus.ofm_address_write), e.addr);
               chk("wr_sel", int'(bus.ofm_sel), e.sel);
               chk("wr_cycle", cyc, e.cyc);
            end
         end
         if (bus.start_to_next && run_active) begin
            pulses_seen++;
            chk("start_to_next_cycle", cyc, pulse_cyc);
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 once the monitor has counted cycle n.
   task automatic tick_to(int n);
      int guard = 0;
      while (cyc != n && guard < 4000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 4000) chk("wait_timeout", cyc, n);
   endtask

   task automatic check_reset_outputs();
      chk("rst_end_to_previous", int'(bus.end_to_previous), 1);
      chk("rst_start_to_next", int'(bus.start_to_next), 0);
      chk("rst_ifm_enable_read", int'(bus.ifm_enable_read), 0);
      chk("rst_ifm_address_read", int'(bus.ifm_address_read), 0);
      chk("rst_ifm_sel", int'(bus.ifm_sel), 0);
      chk("rst_pool_load", int'(bus.pool_load), 0);
      chk("rst_pool_enable", int'(bus.pool_enable), 0);
      chk("rst_ofm_enable_write", int'(bus.ofm_enable_write), 0);
      chk("rst_ofm_address_write", int'(bus.ofm_address_write), 0);
      chk("rst_ofm_sel", int'(bus.ofm_sel), 0);
   endtask

   // busy_until: 0 = downstream free throughout, else end_from_next rises in that cycle.
   task automatic run_bank(int busy_until, int extra_start, int reset_at);
      bus.end_from_next = (busy_until == 0);
      build_model();
      pulse_cyc = (busy_until > 803) ? busy_until : 803;
      bus.start_from_previous = 1'b1;
      @(posedge clk);
      #1;
      bus.start_from_previous = 1'b0;
      run_active = 1'b1;
      if (reset_at > 0) begin
         tick_to(reset_at - 1);
         #2;
         reset = 1'b1;
         #1;
         check_reset_outputs();
         rq.delete();
         pq.delete();
         wq.delete();
         run_active = 1'b0;
         repeat (2) @(posedge clk);
         #1;
         reset = 1'b0;
      end else begin
         if (extra_start > 0) begin
            tick_to(extra_start - 1);
            bus.start_from_previous = 1'b1;
            @(posedge clk);
            #1;
            bus.start_from_previous = 1'b0;
         end
         if (busy_until > 0) begin
            tick_to(busy_until - 1);
            bus.end_from_next = 1'b1;
         end
         tick_to(pulse_cyc + 1);
         chk("start_to_next_pulses", pulses_seen, 1);
         run_active = 1'b0;
         chk("reads_left", rq.size(), 0);
         chk("pool_strobes_left", pq.size(), 0);
         chk("writes_left", wq.size(), 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.start_from_previous = 1'b0;
      bus.end_from_next = 1'b0;
      #2;
      check_reset_outputs();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      run_bank(0, 0, 0);
      run_bank(900, 0, 0);
      run_bank(0, 400, 0);
      run_bank(0, 0, 300);
      run_bank(0, 0, 0);
      for (int n = 0; n < 2; n++) begin
         repeat ($urandom_range(0, 5)) @(posedge clk);
         #1;
         run_bank(($urandom_range(0, 1) == 1) ? int'($urandom_range(804, 1000)) : 0,
                  int'($urandom_range(2, 700)), 0);
      end
      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
